// File: rtl/pc_sequencer.sv
// Program-counter sequencer with a hardware return-address stack.
// Each non-stalled cycle performs one action: interrupt, return, jump/call or sequential step.
module pc_sequencer #(
    parameter int unsigned             WORD_WIDTH  = 32,
    parameter int unsigned             STACK_DEPTH = 16,
    parameter logic [WORD_WIDTH-1:0]   RESET_PC    = '0
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               stall,
    input  logic                               jump_immediate,
    input  logic                               branch,
    input  logic                               call,
    input  logic                               ret,
    input  logic [WORD_WIDTH-1:0]              immediate,
    input  logic                               interrupt_req,
    input  logic [WORD_WIDTH-1:0]              interrupt_vector,
    output logic [WORD_WIDTH-1:0]              pc,
    output logic [$clog2(STACK_DEPTH):0]       depth,
    output logic                               flush,
    output logic                               interrupt_ack,
    output logic                               overflow_fault,
    output logic                               underflow_fault
);

    localparam int unsigned AW = $clog2(STACK_DEPTH);
    localparam int unsigned DW = AW + 1;

    logic [WORD_WIDTH-1:0] pc_q, pc_d;
    logic [DW-1:0]         depth_q, depth_d;
    logic                  flush_q, flush_d;
    logic                  ack_q, ack_d;
    logic                  ovf_q, ovf_d;
    logic                  unf_q, unf_d;

    logic [WORD_WIDTH-1:0] stack_q [STACK_DEPTH];

    logic                  stack_full;
    logic                  stack_empty;
    logic [WORD_WIDTH-1:0] pc_inc;
    logic [AW-1:0]         top_idx;
    logic [AW-1:0]         push_idx;
    logic                  push_en;
    logic [WORD_WIDTH-1:0] push_data;

    // branch only qualifies statistics elsewhere; sequencing ignores it
    logic unused_branch;
    assign unused_branch = branch;

    assign stack_full  = (depth_q == DW'(STACK_DEPTH));
    assign stack_empty = (depth_q == '0);
    assign pc_inc      = pc_q + WORD_WIDTH'(1);
    assign top_idx     = AW'(depth_q - DW'(1));
    // Only used when not full, so the low bits address the next free slot
    assign push_idx    = depth_q[AW-1:0];

    // Next-state selection in priority order: interrupt > ret > jump/call > sequential
    always_comb begin
        pc_d      = pc_q;
        depth_d   = depth_q;
        flush_d   = 1'b0;
        ack_d     = 1'b0;
        ovf_d     = ovf_q;
        unf_d     = unf_q;
        push_en   = 1'b0;
        push_data = pc_inc;

        if (!stall) begin
            if (interrupt_req && !stack_full) begin
                // Current instruction is discarded and re-executed on return
                push_en   = 1'b1;
                push_data = pc_q;
                depth_d   = depth_q + DW'(1);
                pc_d      = interrupt_vector;
                flush_d   = 1'b1;
                ack_d     = 1'b1;
            end else begin
                if (interrupt_req) begin
                    ovf_d = 1'b1;
                end
                if (ret) begin
                    if (!stack_empty) begin
                        pc_d    = stack_q[top_idx];
                        depth_d = depth_q - DW'(1);
                        flush_d = 1'b1;
                    end else begin
                        pc_d  = pc_inc;
                        unf_d = 1'b1;
                    end
                end else if (jump_immediate) begin
                    pc_d    = immediate;
                    flush_d = 1'b1;
                    if (call) begin
                        if (!stack_full) begin
                            push_en   = 1'b1;
                            push_data = pc_inc;
                            depth_d   = depth_q + DW'(1);
                        end else begin
                            ovf_d = 1'b1;
                        end
                    end
                end else begin
                    pc_d = pc_inc;
                end
            end
        end
    end

    // Control and status registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q    <= RESET_PC;
            depth_q <= '0;
            flush_q <= 1'b0;
            ack_q   <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            depth_q <= depth_d;
            flush_q <= flush_d;
            ack_q   <= ack_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Return-address storage; contents above depth are never read, so no reset
    always_ff @(posedge clk) begin
        if (push_en && !reset) begin
            stack_q[push_idx] <= push_data;
        end
    end

    assign pc              = pc_q;
    assign depth           = depth_q;
    assign flush           = flush_q;
    assign interrupt_ack   = ack_q;
    assign overflow_fault  = ovf_q;
    assign underflow_fault = unf_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: stimulus pushes expected state, monitor pops and compares.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        reset, stall, jump_immediate, branch, call, ret, interrupt_req;
    logic [31:0] immediate, interrupt_vector;
    logic [31:0] pc;
    logic [4:0]  depth;
    logic        flush, interrupt_ack, overflow_fault, underflow_fault;

    typedef struct {
        logic [31:0] pc;
        int          depth;
        logic        flush;
        logic        ack;
        logic        ovf;
        logic        unf;
        string       name;
    } exp_t;

    exp_t q[$];
    exp_t m_e;
    int   n_cmp = 0;
    int   n_err = 0;

    pc_sequencer #(
        .WORD_WIDTH (32),
        .STACK_DEPTH(16),
        .RESET_PC   (32'h0)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .stall           (stall),
        .jump_immediate  (jump_immediate),
        .branch          (branch),
        .call            (call),
        .ret             (ret),
        .immediate       (immediate),
        .interrupt_req   (interrupt_req),
        .interrupt_vector(interrupt_vector),
        .pc              (pc),
        .depth           (depth),
        .flush           (flush),
        .interrupt_ack   (interrupt_ack),
        .overflow_fault  (overflow_fault),
        .underflow_fault (underflow_fault)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs on the falling edge and queue the state expected after the next rise
    task automatic cyc(input logic rs, input logic st, input logic ji, input logic br,
                       input logic ca, input logic rt, input logic ir,
                       input logic [31:0] imm, input logic [31:0] vec,
                       input logic [31:0] epc, input int edep, input logic ef,
                       input logic ea, input logic eo, input logic eu, input string nm);
        exp_t e;
        @(negedge clk);
        reset            = rs;
        stall            = st;
        jump_immediate   = ji;
        branch           = br;
        call             = ca;
        ret              = rt;
        interrupt_req    = ir;
        immediate        = imm;
        interrupt_vector = vec;
        e.pc = epc; e.depth = edep; e.flush = ef; e.ack = ea; e.ovf = eo; e.unf = eu; e.name = nm;
        q.push_back(e);
    endtask

    // Monitor: outputs are valid every cycle, checked shortly after each rising edge
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (q.size() > 0) begin
                m_e = q.pop_front();
                n_cmp++;
                if (pc !== m_e.pc || int'(depth) != m_e.depth || flush !== m_e.flush ||
                    interrupt_ack !== m_e.ack || overflow_fault !== m_e.ovf ||
                    underflow_fault !== m_e.unf) begin
                    n_err++;
                    $display("FAIL %s: got pc=%h depth=%0d flush=%b ack=%b ovf=%b unf=%b, want pc=%h depth=%0d flush=%b ack=%b ovf=%b unf=%b",
                             m_e.name, pc, depth, flush, interrupt_ack, overflow_fault,
                             underflow_fault, m_e.pc, m_e.depth, m_e.flush, m_e.ack, m_e.ovf,
                             m_e.unf);
                end
            end
        end
    end

    logic [31:0] tgt [17];
    logic [31:0] ret_pc;

    initial begin
        reset = 1'b1; stall = 1'b0; jump_immediate = 1'b0; branch = 1'b0; call = 1'b0;
        ret = 1'b0; interrupt_req = 1'b0; immediate = '0; interrupt_vector = '0;

        // Reset overrides stall and a pending jump
        cyc(1, 1, 1, 0, 0, 0, 0, 32'h55, 0, 32'h0, 0, 0, 0, 0, 0, "reset_over_stall");
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 0, 0, 0, "reset");
        for (int i = 1; i <= 5; i++)
            cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'(i), 0, 0, 0, 0, 0, "idle_seq");

        // Call from pc=5, ret from 0x102
        cyc(0, 0, 1, 0, 1, 0, 0, 32'h100, 0, 32'h100, 1, 1, 0, 0, 0, "call_0x100");
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h101, 1, 0, 0, 0, 0, "in_sub_1");
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h102, 1, 0, 0, 0, 0, "in_sub_2");
        cyc(0, 0, 0, 0, 0, 1, 0, 0, 0, 32'h6, 0, 1, 0, 0, 0, "ret_to_6");
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h7, 0, 0, 0, 0, 0, "after_ret");

        // branch and call without jump_immediate do nothing special
        cyc(0, 0, 0, 1, 0, 0, 0, 32'h999, 0, 32'h8, 0, 0, 0, 0, 0, "branch_only");
        cyc(0, 0, 0, 0, 1, 0, 0, 32'h999, 0, 32'h9, 0, 0, 0, 0, 0, "call_no_jump");
        cyc(0, 0, 1, 1, 0, 0, 0, 32'h40, 0, 32'h40, 0, 1, 0, 0, 0, "jump_0x40");

        // PC wraps modulo 2^32
        cyc(0, 0, 1, 0, 0, 0, 0, 32'hFFFF_FFFF, 0, 32'hFFFF_FFFF, 0, 1, 0, 0, 0, "jump_max");
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 0, 0, 0, "pc_wrap");

        // Interrupt beats jump and ret; pushes the interrupted pc
        cyc(0, 0, 1, 0, 0, 0, 0, 32'h20, 0, 32'h20, 0, 1, 0, 0, 0, "jump_0x20");
        cyc(0, 0, 1, 0, 0, 1, 1, 32'h999, 32'h80, 32'h80, 1, 1, 1, 0, 0, "irq_taken");
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 32'h80, 32'h81, 1, 0, 0, 0, 0, "irq_ack_pulse");
        cyc(0, 0, 0, 0, 0, 1, 0, 0, 0, 32'h20, 0, 1, 0, 0, 0, "irq_return");

        // Stall holds everything for 3 cycles, then the jump goes
        cyc(0, 1, 1, 0, 0, 1, 1, 32'h300, 32'h80, 32'h20, 0, 0, 0, 0, 0, "stall_1");
        cyc(0, 1, 1, 0, 0, 0, 0, 32'h300, 0, 32'h20, 0, 0, 0, 0, 0, "stall_2");
        cyc(0, 1, 1, 0, 0, 0, 0, 32'h300, 0, 32'h20, 0, 0, 0, 0, 0, "stall_3");
        cyc(0, 0, 1, 0, 0, 0, 0, 32'h300, 0, 32'h300, 0, 1, 0, 0, 0, "jump_after_stall");

        // 17 nested calls: 16 push, the 17th overflows but still redirects
        for (int i = 0; i < 17; i++) tgt[i] = 32'h1000 + 32'(i) * 32'h10;
        for (int i = 0; i < 17; i++)
            cyc(0, 0, 1, 0, 1, 0, 0, tgt[i], 0, tgt[i], (i < 16) ? i + 1 : 16, 1, 0,
                (i == 16) ? 1'b1 : 1'b0, 0, "nested_call");
        // Interrupt at full is refused; the jump beneath it proceeds
        cyc(0, 0, 1, 0, 0, 0, 1, 32'h2000, 32'h80, 32'h2000, 16, 1, 0, 1, 0, "irq_at_full");
        // Unwind: ret j returns to the pc after call 15-j
        for (int j = 0; j < 16; j++) begin
            ret_pc = (j == 15) ? 32'h301 : tgt[14 - j] + 32'h1;
            cyc(0, 0, 0, 0, 0, 1, 0, 0, 0, ret_pc, 15 - j, 1, 0, 1, 0, "unwind_ret");
        end
        // Ret at empty wins over jump but only increments
        cyc(0, 0, 1, 0, 0, 1, 0, 32'h777, 0, 32'h302, 0, 0, 0, 1, 1, "ret_underflow");
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h303, 0, 0, 0, 1, 1, "faults_sticky");

        // Reset in the middle of a call chain with an interrupt pending
        cyc(0, 0, 1, 0, 1, 0, 0, 32'h500, 0, 32'h500, 1, 1, 0, 1, 1, "chain_1");
        cyc(0, 0, 1, 0, 1, 0, 0, 32'h600, 0, 32'h600, 2, 1, 0, 1, 1, "chain_2");
        cyc(0, 0, 1, 0, 1, 0, 0, 32'h700, 0, 32'h700, 3, 1, 0, 1, 1, "chain_3");
        cyc(1, 0, 0, 0, 0, 0, 1, 0, 32'h80, 32'h0, 0, 0, 0, 0, 0, "reset_mid_chain");
        cyc(0, 0, 0, 0, 0, 1, 0, 0, 0, 32'h1, 0, 0, 0, 0, 1, "post_reset_ret_empty");
        cyc(0, 0, 1, 0, 1, 0, 0, 32'h50, 0, 32'h50, 1, 1, 0, 0, 1, "post_reset_call");
        cyc(0, 0, 0, 0, 0, 1, 0, 0, 0, 32'h2, 0, 1, 0, 0, 1, "post_reset_ret");

        // Let the monitor drain the queue, bounded
        @(negedge clk);
        ret = 1'b0; jump_immediate = 1'b0; call = 1'b0;
        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        #3;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d entries left, want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter WORD_WIDTH, default 32, width of PC, immediate and vector.
REQ-002 Parameter STACK_DEPTH, default 16, number of return-address entries (power of two, >=2).
REQ-003 Parameter RESET_PC, default 0, PC value loaded on reset.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 stall  input  1  hold all state this cycle.
REQ-007 jump_immediate  input  1  taken decision from jump/branch decode for current instruction.
REQ-008 branch  input  1  current instruction is a conditional branch (statistics/flush qualifier only).
REQ-009 call  input  1  current instruction is CALLI; meaningful only with jump_immediate=1.
REQ-010 ret  input  1  current instruction is a return.
REQ-011 immediate  input  WORD_WIDTH  jump/call target.
REQ-012 interrupt_req  input  1  level interrupt request.
REQ-013 interrupt_vector  input  WORD_WIDTH  interrupt entry address.
REQ-014 pc  output  WORD_WIDTH  registered program counter.
REQ-015 depth  output  $clog2(STACK_DEPTH)+1  registered count of valid stack entries.
REQ-016 flush  output  1  registered; high one cycle after any PC redirect.
REQ-017 interrupt_ack  output  1  registered one-cycle pulse when interrupt taken.
REQ-018 overflow_fault  output  1  sticky; call or interrupt attempted at full.
REQ-019 underflow_fault  output  1  sticky; ret attempted at empty.

Function
REQ-020 Per non-stalled cycle exactly one action, priority: interrupt > ret > jump_immediate > sequential.
REQ-021 Sequential: pc <= pc+1 modulo 2^WORD_WIDTH; flush <= 0.
REQ-022 Jump (jump_immediate=1, call=0): pc <= immediate; flush <= 1.
REQ-023 Call (jump_immediate=1, call=1, depth<STACK_DEPTH): push pc+1, depth+1, pc <= immediate, flush <= 1.
REQ-024 Call at depth==STACK_DEPTH: no push, depth unchanged, pc <= immediate, flush <= 1, overflow_fault <= 1.
REQ-025 call=1 with jump_immediate=0 has no effect (sequential).
REQ-026 Ret (depth>0): pc <= top entry, depth-1, flush <= 1; jump_immediate/call ignored.
REQ-027 Ret at depth==0: pc <= pc+1, depth stays 0, flush <= 0, underflow_fault <= 1.
REQ-028 Interrupt taken when interrupt_req=1, stall=0 and depth<STACK_DEPTH: push current pc (instruction discarded, re-executed on return), depth+1, pc <= interrupt_vector, flush <= 1, interrupt_ack <= 1; ret/jump/call ignored.
REQ-029 Interrupt request at depth==STACK_DEPTH: not taken, interrupt_ack stays 0, overflow_fault <= 1, remaining priority applies normally.
REQ-030 interrupt_ack and flush are 0 in any cycle not covered by REQ-022/023/024/026/028.
REQ-031 stall=1: pc, depth, stack contents, faults unchanged; flush and interrupt_ack <= 0; all other inputs ignored.
REQ-032 Stack is LIFO; entries above depth are don't-care and never observable on pc.
REQ-033 Faults clear only on reset.
REQ-034 branch does not alter sequencing; jump_immediate alone decides the redirect.

Reset
REQ-035 On reset (overrides stall and all inputs): pc=RESET_PC, depth=0, flush=0, interrupt_ack=0, overflow_fault=0, underflow_fault=0; stack contents don't-care.
REQ-036 Reset asserted mid-sequence (e.g. during call chain) discards all stack entries; first post-reset action behaves as from empty stack.

Verification
REQ-037 Reset, 4 idle cycles -> pc 0,1,2,3,4; depth 0; flush 0.
REQ-038 At pc=5 call to 0x100, then ret at pc=0x102 -> pc 0x100, depth 1, flush 1; then pc 6, depth 0, flush 1.
REQ-039 STACK_DEPTH=16, 17 nested calls -> depth saturates 16, overflow_fault=1 on 17th, pc still equals 17th target; 16 rets unwind in exact reverse order; 17th ret -> underflow_fault=1, pc increments.
REQ-040 interrupt_req with jump_immediate=1 at pc=0x20, vector 0x80 -> pc 0x80, interrupt_ack 1 one cycle, pushed 0x20; ret returns pc 0x20.
REQ-041 stall held 3 cycles during jump_immediate=1 -> pc, depth unchanged, flush 0; jump taken on first stall=0 cycle.
REQ-042 Reset asserted with depth=3 and interrupt_req=1 -> pc=RESET_PC, depth 0, interrupt_ack 0, faults 0.
